dram_resp: RTL
==============

Name: dram_resp

Overview:
- Responder end of the DRAM read/write handshake used by the instruction fetch and load/store units.
- Single-port on-chip word memory with programmable read/write latency.
- Services one transaction at a time. Alternating priority arbitrates between a pending read and a pending write.
- Sits between the fetch/memory stages and the memory array; stands in for external DRAM on FPGA.

Parameters:
ADDR_W, 14, word-address width; memory depth is 2**ADDR_W 32-bit words
RD_LAT, 4, cycles from read acceptance to rd_fin (legal range 1..15)
WR_LAT, 2, cycles from write acceptance to wr_fin (legal range 1..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
dram_rd_req  input  1  read request; held high by the initiator until it sees dram_rd_fin
dram_rd_addr  input  32  byte address, stable while dram_rd_req is high
dram_rd_fin  output  1  one-cycle pulse; dram_rd_data is valid in the same cycle
dram_rd_data  output  32  read word; holds its value until the next read completes
dram_wr_req  input  1  write request; held high until dram_wr_fin
dram_wr_addr  input  32  byte address
dram_wr_data  input  32  write word
dram_wr_be  input  4  byte enables; bit i writes byte lane [8i+7:8i]
dram_wr_fin  output  1  one-cycle pulse; the write is committed when this pulse occurs

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE, cnt=0, last_grant=WRITE.
  - dram_rd_fin=0, dram_wr_fin=0, dram_rd_data=0.
  - Memory contents are not cleared.
  - A reset mid-transaction aborts it. No fin is issued, and no write is committed if reset precedes commit.
- Word index is addr[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo the memory size. addr[1:0] is ignored (see the optional feature).
- States: IDLE, RD_WAIT, WR_WAIT, RD_DONE, WR_DONE, RELEASE.
- IDLE:
  - Only dram_rd_req: accept the read, latch the word index, cnt<=RD_LAT-1, go to RD_WAIT.
  - Only dram_wr_req: accept the write, latch the index, data and be; cnt<=WR_LAT-1; go to WR_WAIT.
  - Both requests: grant the opposite of last_grant, then update last_grant.
- RD_WAIT:
  - While cnt!=0, decrement cnt.
  - When cnt==0, read the memory into dram_rd_data, assert dram_rd_fin, go to RD_DONE.
- WR_WAIT:
  - While cnt!=0, decrement cnt.
  - When cnt==0, write the enabled byte lanes, assert dram_wr_fin, go to WR_DONE.
- RD_DONE / WR_DONE: deassert the fin (pulse width is exactly 1 cycle), go to RELEASE.
- RELEASE:
  - Wait until the completed port's req is low, then go to IDLE.
  - This prevents the initiator's one-cycle-late req drop from being taken as a new request.
  - The other port's pending req is ignored until IDLE.
- Timing:
  - Acceptance edge = E0. dram_rd_fin is high in the cycle after edge E0+RD_LAT, so RD_LAT=1 gives fin in the cycle after E0+1.
  - Minimum spacing between two accepted requests on the same port is RD_LAT+3 cycles (read) and WR_LAT+3 cycles (write).
- Read-after-write to the same address returns the new data, because the write commits before returning to IDLE.
- Address/data changing while req is high are ignored after acceptance, since they are latched.

Optional Feature:
- Macro DRAM_RESP_MISALIGN_CHECK_EN.
- Defined:
  - Adds output port dram_err (1 bit).
  - An accepted request with addr[1:0]!=0 still completes normally.
  - dram_err pulses high together with that request's fin.
  - For writes, the memory is not modified.
- Undefined: no dram_err port; addr[1:0] is silently ignored and writes proceed.

Decomposition:
- Shared package dram_pkg holds:
  - state encoding constants (3-bit);
  - WORD_W=32 and BE_W=4;
  - the grant encoding (READ=0, WRITE=1).
- One sub-module, dram_mem_array:
  - synchronous single-port RAM with byte-enable write and registered read, inferable as BRAM;
  - dram_resp issues its read one cycle early in RD_WAIT so that data lands on the fin cycle.

Test Plan:
- Preload word 0x10 (byte addr 0x40) = 0xDEADBEEF; rd_req with addr 0x40, RD_LAT=4, held until fin → rd_fin is a single pulse in the cycle after E0+4, and rd_data=0xDEADBEEF.
- Write addr 0x80, data 0x11223344, be=4'b0101; then read 0x80 from previous contents 0 → read returns 0x00220044.
- rd_req and wr_req raised on the same edge after reset (last_grant=WRITE) → read is served first. A second simultaneous pair is then served write-first.
- Initiator holds rd_req high one cycle after fin (fetch-style) → no second read is accepted, and exactly one fin pulse occurs.
- reset asserted two cycles into WR_WAIT → no wr_fin, and the target word is unchanged. The next read of it returns the old value.
- Address 0x0001_0040 with ADDR_W=14 → aliases word 0x10; with the macro, addr 0x42 completes with dram_err=1 and the write is suppressed.

Source files
------------

// File: rtl/dram_pkg.sv
// ---------------------------------------------------------------------------
// dram_pkg
// Shared definitions for the dram_resp responder and its memory array:
//   WORD_W / BE_W  - data word width and byte-enable width
//   state_t        - 3-bit responder FSM state encoding
//   grant_t        - arbitration grant encoding (READ=0, WRITE=1)
// ---------------------------------------------------------------------------
package dram_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_WR_WAIT = 3'd2,
        S_RD_DONE = 3'd3,
        S_WR_DONE = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_t;

endpackage

// File: rtl/dram_mem_array.sv
// ---------------------------------------------------------------------------
// dram_mem_array
// Synchronous single-port word RAM with byte-enable write and registered read.
// Ports:
//   clk, reset  - clock; synchronous active-high reset (clears read register only)
//   en, we      - access enable; write when we=1, read when we=0
//   be          - byte enables for writes, bit i covers lane [8i+7:8i]
//   addr        - word index
//   wdata       - write word
//   rdata       - read word; holds until the next read access
// ---------------------------------------------------------------------------
module dram_mem_array
    import dram_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Array is deliberately left without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dram_resp.sv
// ---------------------------------------------------------------------------
// dram_resp
// Responder end of the DRAM read/write handshake backed by an on-chip word
// memory with fixed read/write latency. One transaction at a time; when read
// and write requests collide the grant alternates.
// Ports:
//   clk, reset                  - clock; synchronous active-high reset
//   dram_rd_req/addr            - read request (held until fin), byte address
//   dram_rd_fin/data            - one-cycle completion pulse, read word
//   dram_wr_req/addr/data/be    - write request, byte address, word, lanes
//   dram_wr_fin                 - one-cycle completion pulse (write committed)
//   dram_err                    - only with DRAM_RESP_MISALIGN_CHECK_EN:
//                                 pulses with fin when addr[1:0]!=0
// Optional feature macro: DRAM_RESP_MISALIGN_CHECK_EN
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for a request, arbitrates collisions
// S_RD_WAIT | read latency countdown; memory read issued when cnt==0
// S_WR_WAIT | write latency countdown; memory written when cnt==0
// S_RD_DONE | dram_rd_fin high, read data valid
// S_WR_DONE | dram_wr_fin high
// S_RELEASE | wait for the served port to drop its request
// ---------------------------------------------------------------------------
module dram_resp
    import dram_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dram_rd_req,
    input  logic [31:0]       dram_rd_addr,
    output logic              dram_rd_fin,
    output logic [WORD_W-1:0] dram_rd_data,
    input  logic              dram_wr_req,
    input  logic [31:0]       dram_wr_addr,
    input  logic [WORD_W-1:0] dram_wr_data,
    input  logic [BE_W-1:0]   dram_wr_be,
`ifdef DRAM_RESP_MISALIGN_CHECK_EN
    output logic              dram_err,
`endif
    output logic              dram_wr_fin
);

    state_t              state, state_nx;
    logic [3:0]          cnt;
    grant_t              last_grant;
    grant_t              cur_port;
    logic [ADDR_W-1:0]   idx;
    logic [WORD_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                accept_rd, accept_wr;
    logic                mem_en, mem_we;
    logic                both_req;

    // Address bits outside the word index are intentionally discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dram_rd_addr[31:ADDR_W+2], dram_rd_addr[1:0],
                                dram_wr_addr[31:ADDR_W+2], dram_wr_addr[1:0]};

    assign both_req = dram_rd_req && dram_wr_req;

    always_comb begin
        state_nx  = state;
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            S_IDLE: begin
                if (both_req) begin
                    if (last_grant == GNT_WRITE) accept_rd = 1'b1;
                    else                         accept_wr = 1'b1;
                end else if (dram_rd_req) begin
                    accept_rd = 1'b1;
                end else if (dram_wr_req) begin
                    accept_wr = 1'b1;
                end
                if (accept_rd) state_nx = S_RD_WAIT;
                if (accept_wr) state_nx = S_WR_WAIT;
            end
            S_RD_WAIT: begin
                if (cnt == 4'd0) begin
                    mem_en   = 1'b1;
                    state_nx = S_RD_DONE;
                end
            end
            S_WR_WAIT: begin
                if (cnt == 4'd0) begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    state_nx = S_WR_DONE;
                end
            end
            S_RD_DONE: state_nx = S_RELEASE;
            S_WR_DONE: state_nx = S_RELEASE;
            S_RELEASE: begin
                if (cur_port == GNT_READ ? !dram_rd_req : !dram_wr_req)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef DRAM_RESP_MISALIGN_CHECK_EN
    logic err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            last_grant <= GNT_WRITE;
            cur_port   <= GNT_READ;
            idx        <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
`ifdef DRAM_RESP_MISALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (accept_rd) begin
                idx      <= dram_rd_addr[ADDR_W+1:2];
                cnt      <= 4'(RD_LAT - 1);
                cur_port <= GNT_READ;
                if (both_req) last_grant <= GNT_READ;
`ifdef DRAM_RESP_MISALIGN_CHECK_EN
                err_q    <= (dram_rd_addr[1:0] != 2'b00);
`endif
            end else if (accept_wr) begin
                idx      <= dram_wr_addr[ADDR_W+1:2];
                wdata_q  <= dram_wr_data;
                be_q     <= dram_wr_be;
                cnt      <= 4'(WR_LAT - 1);
                cur_port <= GNT_WRITE;
                if (both_req) last_grant <= GNT_WRITE;
`ifdef DRAM_RESP_MISALIGN_CHECK_EN
                // A misaligned write completes but touches no byte lane.
                err_q    <= (dram_wr_addr[1:0] != 2'b00);
                if (dram_wr_addr[1:0] != 2'b00) be_q <= '0;
`endif
            end else if ((state == S_RD_WAIT || state == S_WR_WAIT) && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Gating with reset keeps an aborted write from committing on the reset edge.
    dram_mem_array #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .reset (reset),
        .en    (mem_en && !reset),
        .we    (mem_we),
        .be    (be_q),
        .addr  (idx),
        .wdata (wdata_q),
        .rdata (dram_rd_data)
    );

    assign dram_rd_fin = (state == S_RD_DONE);
    assign dram_wr_fin = (state == S_WR_DONE);
`ifdef DRAM_RESP_MISALIGN_CHECK_EN
    assign dram_err = err_q && (dram_rd_fin || dram_wr_fin);
`endif

endmodule
